// File: rtl/fifo_lvl_pkg.sv
// ============================================================================
// Module : fifo_lvl_pkg
// Brief  : Shared mode strings and sizing helper for the fifo_lvl family.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fifo_lvl_pkg;

    localparam string FIFO_MODE_FWFT  = "fwft";
    localparam string FIFO_MODE_STD   = "std";
    localparam string FIFO_CLEAR_SYNC = "sync";
    localparam string FIFO_CLEAR_NONE = "none";

    // Level counter width: one bit more than the pointer so DEPTH itself fits.
    function automatic int fifo_lb(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module : fifo_ram
// Brief  : WIDTH x DEPTH storage, one synchronous write port, one async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // No reset on the array so it stays mappable to distributed RAM.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_lvl.sv
// ============================================================================
// Module : fifo_lvl
// Brief  : Single-clock FIFO with level, thresholds, sticky errors, fwft/std.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fifo_lvl
    import fifo_lvl_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter int    DEPTH = 16,
    parameter string MODE  = "fwft",
    parameter string CLEAR = "sync",
    localparam int   LB    = fifo_lb(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_w,
    input  logic             i_r,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_rvalid,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    input  logic [LB-1:0]    i_af_lvl,
    input  logic [LB-1:0]    i_ae_lvl,
    output logic [LB-1:0]    o_level,
    output logic             o_overflow,
    output logic             o_underflow,
    input  logic             i_err_clr
);

    localparam int AW     = LB - 1;
    localparam bit IS_STD = (MODE == FIFO_MODE_STD);
    localparam bit CLR_EN = (CLEAR == FIFO_CLEAR_SYNC);

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LB-1:0]    r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_clr;
    logic             w_full;
    logic             w_empty;
    logic             w_ra;
    logic             w_wa;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic [WIDTH-1:0] w_rdata;

    assign w_clr   = CLR_EN & i_clr;
    assign w_full  = (r_level == LB'(DEPTH));
    assign w_empty = (r_level == '0);

    // A flush suppresses both requests and any error they would have raised.
    assign w_ra      = i_r & ~w_empty & ~w_clr;
    assign w_wa      = i_w & (~w_full | (i_r & ~w_empty)) & ~w_clr;
    assign w_ovf_set = i_w & ~w_wa & ~w_clr;
    assign w_udf_set = i_r & ~w_ra & ~w_clr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wa) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_ra) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + LB'(w_wa) - LB'(w_ra);
        end
    end

    // A set on the same edge as err_clr takes precedence.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (i_err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wa),
        .i_waddr (r_wptr),
        .i_wdata (i_din),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    generate
        if (IS_STD) begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_rvalid;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_dout   <= '0;
                    r_rvalid <= 1'b0;
                end else if (w_ra) begin
                    r_dout   <= w_rdata;
                    r_rvalid <= 1'b1;
                end else begin
                    r_rvalid <= 1'b0;
                end
            end

            assign o_dout   = r_dout;
            assign o_rvalid = r_rvalid;
        end else begin : g_fwft
            assign o_dout   = w_rdata;
            assign o_rvalid = 1'b0;
        end
    endgenerate

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_level        = r_level;
    assign o_almost_full  = (r_level >= i_af_lvl);
    assign o_almost_empty = (r_level <= i_ae_lvl);
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_lvl.sv
// ============================================================================
// Module : tb_fifo_lvl
// Brief  : Directed bench for fifo_lvl; a fwft and a std instance share stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_lvl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LB    = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             w = 1'b0;
    logic             r = 1'b0;
    logic             err_clr = 1'b0;
    logic [LB-1:0]    af_lvl = 3'd3;
    logic [LB-1:0]    ae_lvl = 3'd1;

    logic [WIDTH-1:0] f_dout, s_dout;
    logic             f_rvalid, s_rvalid;
    logic             f_full, s_full;
    logic             f_empty, s_empty;
    logic             f_af, s_af;
    logic             f_ae, s_ae;
    logic [LB-1:0]    f_level, s_level;
    logic             f_ovf, s_ovf;
    logic             f_udf, s_udf;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE("fwft"), .CLEAR("sync")) dut (
        .clk(clk), .rstn(rstn), .i_clr(clr), .i_din(din), .i_w(w), .i_r(r),
        .o_dout(f_dout), .o_rvalid(f_rvalid), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .i_af_lvl(af_lvl), .i_ae_lvl(ae_lvl),
        .o_level(f_level), .o_overflow(f_ovf), .o_underflow(f_udf), .i_err_clr(err_clr)
    );

    fifo_lvl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE("std"), .CLEAR("sync")) dut_std (
        .clk(clk), .rstn(rstn), .i_clr(clr), .i_din(din), .i_w(w), .i_r(r),
        .o_dout(s_dout), .o_rvalid(s_rvalid), .o_full(s_full), .o_empty(s_empty),
        .o_almost_full(s_af), .o_almost_empty(s_ae), .i_af_lvl(af_lvl), .i_ae_lvl(ae_lvl),
        .o_level(s_level), .o_overflow(s_ovf), .o_underflow(s_udf), .i_err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d);
        w = 1'b1; din = d;
        tick();
        w = 1'b0;
    endtask

    task automatic do_read();
        r = 1'b1;
        tick();
        r = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (f_level !== 3'd0 || f_empty !== 1'b1 || f_full !== 1'b0) $display("FAIL reset_flags level=%0d empty=%b full=%b want 0/1/0", f_level, f_empty, f_full); else n_pass++;
        n_total++; if (f_ovf !== 1'b0 || f_udf !== 1'b0) $display("FAIL reset_err ovf=%b udf=%b want 0/0", f_ovf, f_udf); else n_pass++;
        n_total++; if (s_dout !== 8'h00 || s_rvalid !== 1'b0) $display("FAIL reset_std dout=%h rvalid=%b want 00/0", s_dout, s_rvalid); else n_pass++;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            do_write(vals[i]);
            n_total++;
            if (f_level !== 3'(i + 1) || f_af !== (i + 1 >= 3) || f_ae !== (i + 1 <= 1) || f_full !== (i == 3))
                $display("FAIL fill_%0d level=%0d af=%b ae=%b full=%b want level=%0d", i, f_level, f_af, f_ae, f_full, i + 1);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            n_total++; if (f_dout !== vals[i]) $display("FAIL drain_%0d dout=%h want %h", i, f_dout, vals[i]); else n_pass++;
            do_read();
        end
        n_total++; if (f_empty !== 1'b1 || f_level !== 3'd0) $display("FAIL drain_empty empty=%b level=%0d want 1/0", f_empty, f_level); else n_pass++;
    endtask

    task automatic test_full_rw();
        logic [7:0] exp [4];
        exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44; exp[3] = 8'h55;
        do_write(8'h11); do_write(8'h22); do_write(8'h33); do_write(8'h44);
        w = 1'b1; r = 1'b1; din = 8'h55;
        tick();
        w = 1'b0; r = 1'b0;
        n_total++; if (f_level !== 3'd4 || f_ovf !== 1'b0) $display("FAIL full_rw level=%0d ovf=%b want 4/0", f_level, f_ovf); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (f_dout !== exp[i]) $display("FAIL full_rw_rd%0d dout=%h want %h", i, f_dout, exp[i]); else n_pass++;
            do_read();
        end
    endtask

    task automatic test_errors();
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) do_write(exp[i]);
        do_write(8'h66);
        n_total++; if (f_ovf !== 1'b1 || f_level !== 3'd4) $display("FAIL overflow ovf=%b level=%0d want 1/4", f_ovf, f_level); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (f_dout !== exp[i]) $display("FAIL ovf_rd%0d dout=%h want %h", i, f_dout, exp[i]); else n_pass++;
            do_read();
        end
        do_read();
        n_total++; if (f_udf !== 1'b1) $display("FAIL underflow udf=%b want 1", f_udf); else n_pass++;
        err_clr = 1'b1; r = 1'b1;
        tick();
        r = 1'b0;
        n_total++; if (f_udf !== 1'b1) $display("FAIL udf_set_wins udf=%b want 1", f_udf); else n_pass++;
        tick();
        err_clr = 1'b0;
        n_total++; if (f_udf !== 1'b0 || f_ovf !== 1'b0) $display("FAIL err_clr udf=%b ovf=%b want 0/0", f_udf, f_ovf); else n_pass++;
    endtask

    task automatic test_empty_rw_wrap();
        logic [7:0] q [$];
        w = 1'b1; r = 1'b1; din = 8'hA5;
        tick();
        w = 1'b0; r = 1'b0;
        n_total++; if (f_level !== 3'd1 || f_udf !== 1'b1 || f_dout !== 8'hA5) $display("FAIL empty_rw level=%0d udf=%b dout=%h want 1/1/a5", f_level, f_udf, f_dout); else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        q.push_back(8'hA5);
        for (int k = 0; k < 10; k++) begin
            n_total++; if (f_dout !== q[0]) $display("FAIL wrap_%0d dout=%h want %h", k, f_dout, q[0]); else n_pass++;
            w = 1'b1; r = 1'b1; din = 8'(8'h10 + k);
            tick();
            void'(q.pop_front());
            q.push_back(8'(8'h10 + k));
        end
        w = 1'b0; r = 1'b0;
        n_total++; if (f_level !== 3'd1 || f_dout !== 8'h19) $display("FAIL wrap_end level=%0d dout=%h want 1/19", f_level, f_dout); else n_pass++;
        do_read();
        n_total++; if (f_empty !== 1'b1) $display("FAIL wrap_empty empty=%b want 1", f_empty); else n_pass++;
    endtask

    task automatic test_std_mode();
        do_write(8'h11); do_write(8'h22);
        n_total++; if (s_rvalid !== 1'b0) $display("FAIL std_idle rvalid=%b want 0", s_rvalid); else n_pass++;
        do_read();
        n_total++; if (s_dout !== 8'h11 || s_rvalid !== 1'b1 || f_rvalid !== 1'b0) $display("FAIL std_read dout=%h rvalid=%b fwft_rvalid=%b want 11/1/0", s_dout, s_rvalid, f_rvalid); else n_pass++;
        tick();
        n_total++; if (s_dout !== 8'h11 || s_rvalid !== 1'b0 || s_level !== 3'd1) $display("FAIL std_hold dout=%h rvalid=%b level=%0d want 11/0/1", s_dout, s_rvalid, s_level); else n_pass++;
    endtask

    task automatic test_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++; if (f_level !== 3'd0 || f_empty !== 1'b1) $display("FAIL clr_flush level=%0d empty=%b want 0/1", f_level, f_empty); else n_pass++;
        do_read();
        do_write(8'h31); do_write(8'h32); do_write(8'h33);
        n_total++; if (f_level !== 3'd3 || f_udf !== 1'b1) $display("FAIL clr_pre level=%0d udf=%b want 3/1", f_level, f_udf); else n_pass++;
        clr = 1'b1; w = 1'b1; din = 8'h99;
        tick();
        clr = 1'b0; w = 1'b0;
        n_total++; if (f_level !== 3'd0 || f_empty !== 1'b1 || f_udf !== 1'b1 || f_ovf !== 1'b0) $display("FAIL clr_w level=%0d empty=%b udf=%b ovf=%b want 0/1/1/0", f_level, f_empty, f_udf, f_ovf); else n_pass++;
        n_total++; if (s_dout !== 8'h11 || s_rvalid !== 1'b0) $display("FAIL clr_std dout=%h rvalid=%b want 11/0", s_dout, s_rvalid); else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; clr = 1'b1; r = 1'b1;
        tick();
        clr = 1'b0; r = 1'b0;
        n_total++; if (f_udf !== 1'b0) $display("FAIL clr_no_udf udf=%b want 0", f_udf); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        do_read();
        do_write(8'h41); do_write(8'h42);
        w = 1'b1; din = 8'h43;
        #2;
        rstn = 1'b0;
        #1;
        n_total++; if (f_level !== 3'd0 || f_empty !== 1'b1 || f_full !== 1'b0 || f_udf !== 1'b0 || f_ovf !== 1'b0) $display("FAIL rst_mid level=%0d empty=%b full=%b udf=%b ovf=%b want 0/1/0/0/0", f_level, f_empty, f_full, f_udf, f_ovf); else n_pass++;
        n_total++; if (s_dout !== 8'h00 || s_rvalid !== 1'b0 || s_level !== 3'd0) $display("FAIL rst_mid_std dout=%h rvalid=%b level=%0d want 00/0/0", s_dout, s_rvalid, s_level); else n_pass++;
        w = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        n_total++; if (f_level !== 3'd0 || f_empty !== 1'b1) $display("FAIL rst_release level=%0d empty=%b want 0/1", f_level, f_empty); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_errors();
        test_empty_rw_wrap();
        test_std_mode();
        test_clr();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
